// File: rtl/uart_awg_pkg.sv
// Shared constants for the AWG parameter receiver: frame header bytes, word types, FSM encoding.
// No logic of its own. The clog2 helper sizes the parameterised counters.
package uart_awg_pkg;
  localparam logic [7:0] HDR0 = 8'hAA;
  localparam logic [7:0] HDR1 = 8'h55;

  localparam logic [1:0] TYP_DELAY = 2'd0;
  localparam logic [1:0] TYP_LEN   = 2'd1;
  localparam logic [1:0] TYP_ADDR  = 2'd2;
  localparam logic [1:0] TYP_CMD   = 2'd3;

  localparam logic [5:0] CMD_COMMIT = 6'd0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR2 = 3'd1;
  localparam logic [2:0] ST_GA   = 3'd2;
  localparam logic [2:0] ST_IDX  = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
  localparam logic [2:0] ST_CSUM = 3'd5;

  typedef struct packed {
    logic [1:0] typ;
    logic [5:0] idx;
  } idx_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/awg_shadow_regbank.sv
// Shadow and active DELAY/LEN/ADDR word banks; a write lands in shadow on the clock edge after it
// is presented, commit copies every shadow word to active on one edge. No backpressure.
module awg_shadow_regbank
  import uart_awg_pkg::*;
#(
  parameter int NW     = 12,
  parameter int DATA_W = 24,
  parameter int IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [1:0]           wr_typ,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 commit,
  output logic [NW*DATA_W-1:0] delay,
  output logic [NW*DATA_W-1:0] len,
  output logic [NW*DATA_W-1:0] addr
);
  logic [NW*DATA_W-1:0] sh_delay;
  logic [NW*DATA_W-1:0] sh_len;
  logic [NW*DATA_W-1:0] sh_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_delay <= '0;
      sh_len   <= '0;
      sh_addr  <= '0;
      delay    <= '0;
      len      <= '0;
      addr     <= '0;
    end else begin
      if (wr_en) begin
        case (wr_typ)
          TYP_DELAY: sh_delay[int'(wr_idx)*DATA_W +: DATA_W] <= wr_data;
          TYP_LEN:   sh_len[int'(wr_idx)*DATA_W +: DATA_W]   <= wr_data;
          TYP_ADDR:  sh_addr[int'(wr_idx)*DATA_W +: DATA_W]  <= wr_data;
          default: ;
        endcase
      end
      // Shadow is kept across commit so partial updates can be layered on top.
      if (commit) begin
        delay <= sh_delay;
        len   <= sh_len;
        addr  <= sh_addr;
      end
    end
  end
endmodule

// File: rtl/uart_awg_param_rx.sv
// Parses framed, XOR-checksummed UART bytes into shadow register writes and COMMIT commands;
// wr_ack/commit pulse 1 cycle after the CSUM byte. No backpressure: every I_rx_vld byte is consumed.
module uart_awg_param_rx
  import uart_awg_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         NUM_SEG     = 3,
  parameter int         DATA_W      = 24,
  parameter int         TIMEOUT_CYC = 10000,
  parameter logic [4:0] BCAST_GA    = 5'h1F
) (
  input  logic                               I_clk_10M,
  input  logic                               I_rst,
  input  logic [7:0]                         I_rx_data,
  input  logic                               I_rx_vld,
  input  logic [4:0]                         I_ga,
  output logic [NUM_CH*NUM_SEG*DATA_W-1:0]   O_delay,
  output logic [NUM_CH*NUM_SEG*DATA_W-1:0]   O_len,
  output logic [NUM_CH*NUM_SEG*DATA_W-1:0]   O_addr,
  output logic                               O_commit,
  output logic                               O_wr_ack,
  output logic [15:0]                        O_err_cnt,
  output logic                               O_busy
);
  localparam int NW         = NUM_CH * NUM_SEG;
  localparam int DATA_BYTES = (DATA_W + 7) / 8;
  localparam int SH_W       = DATA_BYTES * 8;
  localparam int IDX_W      = (clog2(NW) < 1) ? 1 : clog2(NW);
  localparam int CNT_W      = (clog2(TIMEOUT_CYC) < 1) ? 1 : clog2(TIMEOUT_CYC);

  logic [2:0]       state;
  idx_t             idx_q;
  logic [7:0]       csum;
  logic [SH_W-1:0]  shreg;
  logic [SH_W-1:0]  shreg_next;
  logic [2:0]       byte_cnt;
  logic             ga_ok;
  logic [CNT_W-1:0] gap_cnt;
  logic [15:0]      err_cnt;
  logic             wr_ack;
  logic             commit;

  logic frame_end, csum_ok, idx_ok, accept, frame_err, wr_en, do_commit, timeout;

  always_comb begin
    shreg_next      = shreg << 8;
    shreg_next[7:0] = I_rx_data;
  end

  assign frame_end = (state == ST_CSUM) && I_rx_vld;
  assign csum_ok   = (csum == I_rx_data);
  assign idx_ok    = (idx_q.typ == TYP_CMD) ? (idx_q.idx == CMD_COMMIT)
                                            : ({2'b00, idx_q.idx} < 8'(NW));
  // Frames for another slot are consumed to the end but never counted as errors.
  assign accept    = frame_end && ga_ok && csum_ok && idx_ok;
  assign frame_err = frame_end && ga_ok && !(csum_ok && idx_ok);
  assign wr_en     = accept && (idx_q.typ != TYP_CMD);
  assign do_commit = accept && (idx_q.typ == TYP_CMD);
  assign timeout   = (state != ST_IDLE) && !I_rx_vld && (gap_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      state    <= ST_IDLE;
      idx_q    <= '0;
      csum     <= '0;
      shreg    <= '0;
      byte_cnt <= '0;
      ga_ok    <= 1'b0;
      gap_cnt  <= '0;
      err_cnt  <= '0;
      wr_ack   <= 1'b0;
      commit   <= 1'b0;
    end else begin
      wr_ack  <= wr_en;
      commit  <= do_commit;
      gap_cnt <= (state == ST_IDLE || I_rx_vld || timeout) ? '0 : gap_cnt + 1'b1;
      if ((frame_err || timeout) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;

      if (timeout) begin
        state <= ST_IDLE;
      end else if (I_rx_vld) begin
        case (state)
          ST_IDLE: if (I_rx_data == HDR0) state <= ST_HDR2;
          ST_HDR2: begin
            if (I_rx_data == HDR1)      state <= ST_GA;
            else if (I_rx_data != HDR0) state <= ST_IDLE;
          end
          ST_GA: begin
            ga_ok <= (I_rx_data == {3'b000, I_ga}) || (I_rx_data == {3'b000, BCAST_GA});
            csum  <= I_rx_data;
            state <= ST_IDX;
          end
          ST_IDX: begin
            idx_q    <= idx_t'(I_rx_data);
            csum     <= csum ^ I_rx_data;
            byte_cnt <= '0;
            state    <= ST_DATA;
          end
          ST_DATA: begin
            shreg    <= shreg_next;
            csum     <= csum ^ I_rx_data;
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'(DATA_BYTES - 1)) state <= ST_CSUM;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  awg_shadow_regbank #(
    .NW     (NW),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk     (I_clk_10M),
    .rst     (I_rst),
    .wr_en   (wr_en),
    .wr_typ  (idx_q.typ),
    .wr_idx  (idx_q.idx[IDX_W-1:0]),
    .wr_data (shreg[DATA_W-1:0]),
    .commit  (do_commit),
    .delay   (O_delay),
    .len     (O_len),
    .addr    (O_addr)
  );

  assign O_commit  = commit;
  assign O_wr_ack  = wr_ack;
  assign O_err_cnt = err_cnt;
  assign O_busy    = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_awg_param_rx.sv
// Directed bench: default build (GA=3) plus a DATA_W=16 / 8x2 build sharing the byte bus.
module tb_uart_awg_param_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        vld_a = 1'b0;
  logic        vld_b = 1'b0;
  logic [4:0]  ga = 5'd3;

  logic [287:0] delay_a, len_a, addr_a;
  logic         com_a, ack_a, busy_a;
  logic [15:0]  err_a;
  logic [255:0] delay_b, len_b, addr_b;
  logic         com_b, ack_b, busy_b;
  logic [15:0]  err_b;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;
  logic ack_s, com_s;

  always #50 clk = ~clk;

  uart_awg_param_rx dut_a (
    .I_clk_10M(clk), .I_rst(rst), .I_rx_data(rx_data), .I_rx_vld(vld_a), .I_ga(ga),
    .O_delay(delay_a), .O_len(len_a), .O_addr(addr_a), .O_commit(com_a),
    .O_wr_ack(ack_a), .O_err_cnt(err_a), .O_busy(busy_a)
  );

  uart_awg_param_rx #(.NUM_CH(8), .NUM_SEG(2), .DATA_W(16)) dut_b (
    .I_clk_10M(clk), .I_rst(rst), .I_rx_data(rx_data), .I_rx_vld(vld_b), .I_ga(ga),
    .O_delay(delay_b), .O_len(len_b), .O_addr(addr_b), .O_commit(com_b),
    .O_wr_ack(ack_b), .O_err_cnt(err_b), .O_busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    if (sel) vld_b = 1'b1; else vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    vld_b = 1'b0;
  endtask

  task automatic send_body(input logic [7:0] fga, input logic [7:0] idx,
                           input logic [31:0] d, input bit bad);
    logic [7:0] cs;
    logic [7:0] byt;
    int nb;
    nb = sel ? 2 : 3;
    cs = fga ^ idx;
    send_byte(fga);
    send_byte(idx);
    for (int i = nb - 1; i >= 0; i--) begin
      byt = d[i*8 +: 8];
      cs  = cs ^ byt;
      send_byte(byt);
    end
    send_byte(bad ? (cs ^ 8'h01) : cs);
    ack_s = sel ? ack_b : ack_a;
    com_s = sel ? com_b : com_a;
  endtask

  task automatic send_frame(input logic [7:0] fga, input logic [7:0] idx,
                            input logic [31:0] d, input bit bad);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_body(fga, idx, d, bad);
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {63'd0, |{delay_a, len_a, addr_a}}, 64'd0);
    chk("rst_flags", {60'd0, com_a, ack_a, busy_a, 1'b0}, 64'd0);
    chk("rst_err", err_a, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // DELAY seg1 ch1 write, visible only after COMMIT
    send_frame(8'h03, 8'h05, 32'h123456, 1'b0);
    chk("t1_wr_ack", ack_s, 1'b1);
    chk("t1_no_commit", com_s, 1'b0);
    @(negedge clk);
    chk("t1_ack_pulse_end", ack_a, 1'b0);
    chk("t1_delay_pre", delay_a[5*24 +: 24], 24'h0);
    send_frame(8'h03, 8'hC0, 32'h0, 1'b0);
    chk("t1_commit", com_s, 1'b1);
    chk("t1_commit_no_ack", ack_s, 1'b0);
    chk("t1_delay_post", delay_a[5*24 +: 24], 24'h123456);
    @(negedge clk);
    chk("t1_commit_pulse_end", com_a, 1'b0);

    // Broadcast accepted, foreign slot ignored
    send_frame(8'h1F, 8'h40, 32'hABCDEF, 1'b0);
    chk("t2_bcast_ack", ack_s, 1'b1);
    send_frame(8'h1F, 8'hC0, 32'h0, 1'b0);
    chk("t2_bcast_commit", com_s, 1'b1);
    chk("t2_len0", len_a[23:0], 24'hABCDEF);
    send_frame(8'h07, 8'h40, 32'h111111, 1'b0);
    chk("t2_foreign_ack", ack_s, 1'b0);
    chk("t2_foreign_err", err_a, 16'd0);
    send_frame(8'h03, 8'hC0, 32'h0, 1'b0);
    chk("t2_len0_kept", len_a[23:0], 24'hABCDEF);

    // Frame errors
    send_frame(8'h03, 8'h05, 32'h654321, 1'b1);
    chk("t3_badcs_ack", ack_s, 1'b0);
    chk("t3_badcs_err", err_a, 16'd1);
    send_frame(8'h03, 8'h0C, 32'h000001, 1'b0);
    chk("t3_badidx_ack", ack_s, 1'b0);
    chk("t3_badidx_err", err_a, 16'd2);
    send_frame(8'h03, 8'hC5, 32'h0, 1'b0);
    chk("t3_badcmd_commit", com_s, 1'b0);
    chk("t3_badcmd_err", err_a, 16'd3);
    chk("t3_delay_kept", delay_a[5*24 +: 24], 24'h123456);

    // Inter-byte timeout
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03); send_byte(8'h05);
    chk("t4_busy", busy_a, 1'b1);
    n = 0;
    while (busy_a && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_cycles", n, 10000);
    chk("t4_timeout_err", err_a, 16'd4);
    send_frame(8'h03, 8'h85, 32'h0A0B0C, 1'b0);
    chk("t4_after_ack", ack_s, 1'b1);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03); send_byte(8'h86);
    repeat (9999) @(negedge clk);
    chk("t4_busy_at_expiry", busy_a, 1'b1);
    send_byte(8'h00); send_byte(8'hF0); send_byte(8'h0D);
    send_byte(8'h78);
    chk("t4_expiry_ack", ack_a, 1'b1);
    chk("t4_expiry_err", err_a, 16'd4);
    send_frame(8'h03, 8'hC0, 32'h0, 1'b0);
    chk("t4_addr5", addr_a[5*24 +: 24], 24'h0A0B0C);
    chk("t4_addr6", addr_a[6*24 +: 24], 24'h00F00D);
    chk("t4_delay5_kept", delay_a[5*24 +: 24], 24'h123456);

    // Header resync and abort
    send_byte(8'hAA); send_byte(8'hAA);
    send_frame(8'h03, 8'h02, 32'hDEADBE, 1'b0);
    chk("t5_resync_ack", ack_s, 1'b1);
    send_byte(8'hAA); send_byte(8'h00);
    chk("t5_abort_idle", busy_a, 1'b0);
    chk("t5_abort_err", err_a, 16'd4);

    // Error counter saturation
    force dut_a.err_cnt = 16'hFFFE;
    @(negedge clk);
    release dut_a.err_cnt;
    send_frame(8'h03, 8'h05, 32'h0, 1'b1);
    chk("t6_sat_ffff", err_a, 16'hFFFF);
    send_frame(8'h03, 8'h05, 32'h0, 1'b1);
    chk("t6_sat_hold", err_a, 16'hFFFF);

    // Reset in the middle of the data bytes
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03); send_byte(8'h01); send_byte(8'h12);
    chk("t6_busy_pre_rst", busy_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outputs", {63'd0, |{delay_a, len_a, addr_a}}, 64'd0);
    chk("t6_rst_busy", busy_a, 1'b0);
    chk("t6_rst_err", err_a, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'h03, 8'h01, 32'h010203, 1'b0);
    chk("t6_post_rst_ack", ack_s, 1'b1);

    // Narrow build: 2 data bytes, 16 words
    sel = 1'b1;
    send_frame(8'h03, 8'h0F, 32'hBEEF, 1'b0);
    chk("t6b_ack", ack_s, 1'b1);
    send_frame(8'h03, 8'hC0, 32'h0, 1'b0);
    chk("t6b_commit", com_s, 1'b1);
    chk("t6b_word15", delay_b[15*16 +: 16], 16'hBEEF);
    chk("t6b_err", err_b, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
